// File: rtl/seq_det_pkg.sv
// Shared defaults and configuration record for the serial pattern detector.
package seq_det_pkg;

  localparam int DEF_SEQ_W = 12;
  localparam int DEF_CNT_W = 8;

  typedef struct packed {
    logic [DEF_SEQ_W-1:0] pattern;
    logic [DEF_SEQ_W-1:0] mask;
  } seq_cfg_t;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter; a clear beats a same-cycle increment.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/param_seq_detector.sv
// Serial-bit detector for a programmable, bit-maskable SEQ_W-bit pattern with
// overlap control, a fill guard and a saturating match counter.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x_i,
  input  logic             valid_i,
  input  logic             cfg_load_i,
  input  logic [SEQ_W-1:0] pattern_i,
  input  logic [SEQ_W-1:0] mask_i,
  input  logic             overlap_i,
  input  logic             clr_cnt_i,
  output logic             det_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int FILL_W = $clog2(SEQ_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_W);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  typedef struct packed {
    logic [SEQ_W-1:0] pattern;
    logic [SEQ_W-1:0] mask;
  } cfg_t;

  cfg_t              cfg_q, cfg_d;
  logic [SEQ_W-1:0]  hist_q, hist_d, hist_n;
  logic [FILL_W-1:0] fill_q, fill_d, fill_n;
  logic              det_q, det_d;
  logic              accept;
  logic              match;

  // Next-state logic; fill counts bits accepted since the last restart so an
  // all-zero pattern cannot fire off the cleared history.
  always_comb begin
    accept = valid_i & ~cfg_load_i;
    hist_n = {hist_q[SEQ_W-2:0], x_i};
    if (fill_q == FILL_FULL) begin
      fill_n = FILL_FULL;
    end else begin
      fill_n = fill_q + FILL_ONE;
    end
    match = accept && (fill_n == FILL_FULL) &&
            (((hist_n ^ cfg_q.pattern) & cfg_q.mask) == {SEQ_W{1'b0}});

    cfg_d  = cfg_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    if (cfg_load_i) begin
      cfg_d  = '{pattern: pattern_i, mask: mask_i};
      hist_d = {SEQ_W{1'b0}};
      fill_d = {FILL_W{1'b0}};
    end else if (accept) begin
      hist_d = hist_n;
      fill_d = (match && !overlap_i) ? {FILL_W{1'b0}} : fill_n;
      det_d  = match;
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // State and match-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q  <= '{pattern: {SEQ_W{1'b0}}, mask: {SEQ_W{1'b0}}};
      hist_q <= {SEQ_W{1'b0}};
      fill_q <= {FILL_W{1'b0}};
      det_q  <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (match),
    .clr_i   (clr_cnt_i),
    .cnt_o   (count_o)
  );

  assign det_o = det_q;

endmodule
